// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding word-aligned data-memory access.
// It extends load data and reports misaligned, illegal-funct3 and timeout errors.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic        resp_buserr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [10:0] TimeoutLim = 11'(TIMEOUT);

  state_t      state_q;
  logic        req_ready_q;
  logic        resp_valid_q, resp_mis_q, resp_ill_q, resp_berr_q;
  logic [31:0] resp_rdata_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [1:0]  addr_q;
  logic [2:0]  funct3_q;
  logic [9:0]  cnt_q;

  logic        illegal_d, misaligned_d, timeout_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_data_d;
  logic [10:0] cnt_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    illegal_d    = req_we ? (req_funct3[2] || req_funct3 == 3'b011)
                          : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
    misaligned_d = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    case (req_funct3[1:0])
      2'b00:   begin be_d = 4'b0001 << req_addr[1:0];        wdata_d = {4{req_wdata[7:0]}};  end
      2'b01:   begin be_d = 4'b0011 << {req_addr[1], 1'b0}; wdata_d = {2{req_wdata[15:0]}}; end
      default: begin be_d = 4'b1111;                         wdata_d = req_wdata;            end
    endcase
  end

  // Lane selection uses the latched address; mem_rdata is the full aligned word.
  always_comb begin
    ld_byte = mem_rdata[{addr_q, 3'b000} +: 8];
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data_d = {24'b0, ld_byte};
      3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data_d = {16'b0, ld_half};
      default: ld_data_d = mem_rdata;
    endcase
  end

  // cnt_d is the number of REQ/WAIT cycles including the current one.
  assign cnt_d     = {1'b0, cnt_q} + 11'd1;
  assign timeout_d = (TIMEOUT != 0) && (cnt_d == TimeoutLim);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_mis_q   <= 1'b0;
      resp_ill_q   <= 1'b0;
      resp_berr_q  <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      addr_q       <= '0;
      funct3_q     <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req_valid) begin
            addr_q      <= req_addr[1:0];
            funct3_q    <= req_funct3;
            req_ready_q <= 1'b0;
            if (illegal_d || misaligned_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_ill_q   <= illegal_d;
              resp_mis_q   <= !illegal_d;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= req_we ? wdata_d : 32'b0;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_d[9:0];
          if (mem_gnt || timeout_d) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
          end
          // A grant in the timeout cycle still wins.
          if (mem_gnt) begin
            if (mem_we_q) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end else if (timeout_d) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_berr_q  <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d[9:0];
          if (mem_rvalid) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ld_data_d;
          end else if (timeout_d) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_berr_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_mis_q   <= 1'b0;
          resp_ill_q   <= 1'b0;
          resp_berr_q  <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_illegal    = resp_ill_q;
  assign resp_buserr     = resp_berr_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_be          = mem_be_q;
  assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for lsu with TIMEOUT=4: the stimulus queues expected responses,
// and a negedge monitor pops the queue and compares each response as it appears.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned, resp_illegal, resp_buserr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal), .resp_buserr(resp_buserr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  flags;  // {misaligned, illegal, buserr}
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=resp_valid@%0d required=none", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_flags", {resp_misaligned, resp_illegal, resp_buserr}, mon_e.flags);
          chk("resp_cycle", cyc, mon_e.at);
        end
      end else begin
        chk("idle_resp_zero", {resp_rdata, resp_misaligned, resp_illegal, resp_buserr}, '0);
      end
    end
  end

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({nm, "_idle"}, ok, 1'b1);
  endtask

  // gnt_wait: REQ cycles before the grant; give_gnt=0 never grants.
  // rv_wait: cycles in WAIT before rvalid, negative means rvalid never arrives.
  task automatic access(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] memword,
                        input int gnt_wait, input bit give_gnt, input int rv_wait,
                        input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                        input logic [2:0] exp_flags, input int lat, input int ready_at);
    exp_t e;
    int   t;
    @(posedge clk); #1;
    chk({nm, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    t = cyc;
    e.rdata = exp_rd; e.flags = exp_flags; e.at = t + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom(); req_funct3 = 3'($urandom());
    if (exp_flags[2:1] != 2'b00) begin
      chk({nm, "_nomem"}, mem_req, 1'b0);
    end else begin
      for (int i = 0; i < gnt_wait; i++) begin
        chk({nm, "_memhold"}, {mem_req, mem_we, mem_addr, mem_be, mem_wdata},
            {1'b1, we, exp_maddr, exp_be, exp_wd});
        @(posedge clk); #1;
      end
      if (!give_gnt) begin
        chk({nm, "_req_dropped"}, mem_req, 1'b0);
      end else begin
        chk({nm, "_mem"}, {mem_req, mem_we, mem_addr, mem_be, mem_wdata},
            {1'b1, we, exp_maddr, exp_be, exp_wd});
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        if (!we && rv_wait >= 0) begin
          repeat (rv_wait) begin @(posedge clk); #1; end
          mem_rvalid = 1'b1; mem_rdata = memword;
          @(posedge clk); #1;
          mem_rvalid = 1'b0; mem_rdata = $urandom();
        end
      end
    end
    wait_idle(nm);
    if (ready_at > 0) chk({nm, "_ready_cycle"}, cyc, t + ready_at);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  localparam logic [106:0] IdleOut = {1'b1, 106'b0};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    chk("reset_outputs", {req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        resp_buserr, mem_req, mem_we, mem_addr, mem_be, mem_wdata}, IdleOut);

    //     name     we  f3      addr      wdata     memword   gw gg rv  maddr     be       wdata     rdata     flags   lat rdy
    access("lw",    0, 3'b010, 32'h100,  32'h0,    32'hDEADBEEF, 0, 1, 0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 3'b000, 3, 0);
    access("lb",    0, 3'b000, 32'h103,  32'h0,    32'h80123456, 0, 1, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 3'b000, 3, 0);
    access("lbu",   0, 3'b100, 32'h103,  32'h0,    32'h80123456, 0, 1, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080, 3'b000, 3, 0);
    access("lb_pos",0, 3'b000, 32'h101,  32'h0,    32'h11227F44, 0, 1, 0, 32'h100, 4'b0010, 32'h0, 32'h0000007F, 3'b000, 3, 0);
    access("lh",    0, 3'b001, 32'h102,  32'h0,    32'h80015678, 0, 1, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001, 3'b000, 3, 0);
    access("lhu",   0, 3'b101, 32'h100,  32'h0,    32'h1234F00D, 0, 1, 0, 32'h100, 4'b0011, 32'h0, 32'h0000F00D, 3'b000, 3, 0);
    access("lw_rvw",0, 3'b010, 32'h10C,  32'h0,    32'h0BADF00D, 0, 1, 1, 32'h10C, 4'b1111, 32'h0, 32'h0BADF00D, 3'b000, 4, 0);
    access("sh",    1, 3'b001, 32'h206,  32'h1234ABCD, 32'h0,    3, 1, 0, 32'h204, 4'b1100, 32'hABCDABCD, 32'h0, 3'b000, 5, 0);
    access("sb",    1, 3'b000, 32'h301,  32'h00000077, 32'h0,    0, 1, 0, 32'h300, 4'b0010, 32'h77777777, 32'h0, 3'b000, 2, 0);
    access("sw",    1, 3'b010, 32'h400,  32'hCAFEF00D, 32'h0,    0, 1, 0, 32'h400, 4'b1111, 32'hCAFEF00D, 32'h0, 3'b000, 2, 0);
    access("lw_mis",0, 3'b010, 32'h101,  32'h0,    32'h0,        0, 1, 0, 32'h0,   4'b0000, 32'h0, 32'h0,        3'b100, 1, 0);
    access("ld_ill",0, 3'b011, 32'h101,  32'h0,    32'h0,        0, 1, 0, 32'h0,   4'b0000, 32'h0, 32'h0,        3'b010, 1, 0);
    access("st_ill",1, 3'b100, 32'h000,  32'h5,    32'h0,        0, 1, 0, 32'h0,   4'b0000, 32'h0, 32'h0,        3'b010, 1, 0);
    access("sh_mis",1, 3'b001, 32'h201,  32'h5,    32'h0,        0, 1, 0, 32'h0,   4'b0000, 32'h0, 32'h0,        3'b100, 1, 0);
    access("ld_tmo",0, 3'b010, 32'h100,  32'h0,    32'h0,        0, 1, -1, 32'h100, 4'b1111, 32'h0, 32'h0,       3'b001, 5, 6);
    access("st_tmo",1, 3'b010, 32'h500,  32'h1,    32'h0,        4, 0, 0, 32'h500, 4'b1111, 32'h1, 32'h0,        3'b001, 5, 6);

    // Reset while waiting for read data; late rvalid/gnt must be ignored.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h12345678;
    chk("rst_mid_outputs", {req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        resp_buserr, mem_req, mem_we, mem_addr, mem_be, mem_wdata}, IdleOut);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    chk("rst_late_ignored", {req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        resp_buserr, mem_req, mem_we, mem_addr, mem_be, mem_wdata}, IdleOut);
    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
